// File: rtl/data_to_l2_buffer_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_to_l2_buffer_control_pkg
// Purpose  : Shared cache constants for the L2 write serializer. Includes
//            the default widths, the beats-per-line count, the serializer
//            state encoding and the beat-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package data_to_l2_buffer_control_pkg;

  localparam int L2_BUS_WIDTH_DEF   = 64;
  localparam int BUFFER_WIDTH_DEF   = 128;
  localparam int BEATS_PER_LINE_DEF = BUFFER_WIDTH_DEF / L2_BUS_WIDTH_DEF;

  // Serializer state encoding
  localparam int          STATE_WIDTH = 1;
  localparam logic [0:0]  ST_IDLE     = 1'b0;  // no line held
  localparam logic [0:0]  ST_SEND     = 1'b1;  // line held, beat k on bus

  // A single-beat line still needs a 1-bit counter so the port never collapses
  function automatic int beat_cnt_width(input int num_beats);
    return (num_beats <= 1) ? 1 : $clog2(num_beats);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_to_l2_buffer_control_beat_slice_mux.sv
`default_nettype none
// ============================================================================
// Module   : beat_slice_mux
// Purpose  : Line holding register plus counter-indexed beat select.
//            Drives slice [idx*BEAT_WIDTH +: BEAT_WIDTH] of the held line.
// Revision : 1.0 - initial release
// ============================================================================
module beat_slice_mux #(
  parameter int BEAT_WIDTH = 64,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  load_i,
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic [CNT_WIDTH-1:0]  idx_i,
  output logic [BEAT_WIDTH-1:0] beat_o
);

  localparam int NUM_BEATS = LINE_WIDTH / BEAT_WIDTH;

  logic [LINE_WIDTH-1:0] line_q;

  // Capture a whole line on load; otherwise hold so the beat stays stable
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      line_q <= '0;
    end else if (load_i) begin
      line_q <= line_i;
    end
  end

  generate
    if (NUM_BEATS == 1) begin : g_single
      // Only one slice exists, so the index carries no information
      logic unused_idx;
      assign unused_idx = ^idx_i;
      assign beat_o     = line_q[BEAT_WIDTH-1:0];
    end else begin : g_multi
      logic [BEAT_WIDTH-1:0] slices [NUM_BEATS];
      for (genvar b = 0; b < NUM_BEATS; b++) begin : g_slice
        assign slices[b] = line_q[b*BEAT_WIDTH +: BEAT_WIDTH];
      end
      assign beat_o = slices[idx_i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/data_to_l2_buffer_control.sv
`default_nettype none
// ============================================================================
// Module   : data_to_l2_buffer_control
// Purpose  : Serializes one BUFFER_WIDTH line from the L1 write buffer onto
//            the L2_BUS_WIDTH bus toward L2, lowest slice first, with
//            valid/ready on both sides and no bubble between lines.
// Revision : 1.0 - initial release
// ============================================================================
module data_to_l2_buffer_control
  import data_to_l2_buffer_control_pkg::*;
#(
  parameter int L2_BUS_WIDTH = L2_BUS_WIDTH_DEF,
  parameter int BUFFER_WIDTH = BUFFER_WIDTH_DEF
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    ENB,
  input  logic [BUFFER_WIDTH-1:0] DATA_TO_L2_BUFFER,
  input  logic                    DATA_TO_L2_BUFFER_VALID,
  output logic                    DATA_TO_L2_BUFFER_READY,
  output logic [L2_BUS_WIDTH-1:0] DATA_TO_L2,
  output logic                    DATA_TO_L2_VALID,
  input  logic                    DATA_TO_L2_READY,
  output logic                    DATA_TO_L2_LAST
);

  localparam int                NUM_BEATS = BUFFER_WIDTH / L2_BUS_WIDTH;
  localparam int                CNT_W     = beat_cnt_width(NUM_BEATS);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_BEATS - 1);

  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;

  logic w_last;
  logic w_line_fire;
  logic w_beat_fire;

  assign w_last      = (state_q == ST_SEND) && (cnt_q == LAST_IDX);
  assign w_line_fire = DATA_TO_L2_BUFFER_VALID & DATA_TO_L2_BUFFER_READY;
  assign w_beat_fire = DATA_TO_L2_VALID & DATA_TO_L2_READY;

  // State and beat counter; ENB low freezes both, reset wins over everything
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (ENB) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load a line from IDLE, step beats, chain or drop after last
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_line_fire) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end
      end
      ST_SEND: begin
        if (w_beat_fire) begin
          if (w_last) begin
            cnt_d   = '0;
            state_d = w_line_fire ? ST_SEND : ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake outputs; buffer ready looks through L2 ready so lines chain
  always_comb begin
    DATA_TO_L2_VALID        = ENB & (state_q == ST_SEND);
    DATA_TO_L2_LAST         = w_last;
    DATA_TO_L2_BUFFER_READY = ENB & ((state_q == ST_IDLE) | (w_last & DATA_TO_L2_READY));
  end

  beat_slice_mux #(
    .BEAT_WIDTH (L2_BUS_WIDTH),
    .LINE_WIDTH (BUFFER_WIDTH),
    .CNT_WIDTH  (CNT_W)
  ) u_beat_slice_mux (
    .clk_i  (CLK),
    .rstn_i (RSTN),
    .load_i (w_line_fire),
    .line_i (DATA_TO_L2_BUFFER),
    .idx_i  (cnt_q),
    .beat_o (DATA_TO_L2)
  );

endmodule
`default_nettype wire
